// File: rtl/video_out_pkg.sv
// Shared types and tables for the video output mapper: map index, detect FSM
// states, the M5Display lane permutation and the test-pattern colour bars.
package video_out_pkg;

  typedef enum logic {
    MAP_IDENTITY  = 1'b0,
    MAP_M5DISPLAY = 1'b1
  } map_idx_t;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_FILTER = 2'd1,
    ST_LOCKED = 2'd2
  } detect_state_t;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } video_ctrl_t;

  // Map 1: out[i] = in[MAP1_SRC[i]]
  localparam int unsigned MAP1_WIDTH = 24;
  localparam int unsigned MAP1_SRC [MAP1_WIDTH] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
    22, 20, 18, 16, 14, 23, 21, 19, 17, 15
  };

  localparam int unsigned BAR_SHIFT = 7;
  localparam int unsigned BAR_COUNT = 8;
  localparam logic [23:0] BAR_RGB [BAR_COUNT] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_out_detect.sv
// Board-type detection: 2-FF synchroniser on detect_n, run-length filter and a
// lock FSM that latches the detected map once and holds it until reset.
module video_out_detect
  import video_out_pkg::*;
#(
  parameter int unsigned DETECT_FILTER = 16
) (
  input  logic clock_video,
  input  logic reset_n,
  input  logic detect_n,
  output logic map_sel_detected,
  output logic map_locked
);

  localparam int unsigned CNT_W = $clog2(DETECT_FILTER + 1);

  logic [1:0]       sync_ff;
  logic             detect_sync;
  logic             prev_sample;
  logic             sync_wait;
  logic [CNT_W-1:0] run_cnt;
  detect_state_t    state;

  assign detect_sync = sync_ff[1];

  always_ff @(posedge clock_video) begin
    if (!reset_n) begin
      sync_ff          <= 2'b11;
      state            <= ST_SYNC;
      sync_wait        <= 1'b0;
      prev_sample      <= 1'b1;
      run_cnt          <= '0;
      map_sel_detected <= 1'b0;
      map_locked       <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], detect_n};
      case (state)
        ST_SYNC: begin
          sync_wait <= 1'b1;
          if (sync_wait) begin
            state   <= ST_FILTER;
            run_cnt <= '0;
          end
        end
        ST_FILTER: begin
          prev_sample <= detect_sync;
          // run_cnt == 0 marks the first sample of the run
          if (run_cnt == '0 || detect_sync == prev_sample) begin
            if (run_cnt == CNT_W'(DETECT_FILTER - 1)) begin
              state            <= ST_LOCKED;
              map_locked       <= 1'b1;
              map_sel_detected <= ~detect_sync;
            end else begin
              run_cnt <= run_cnt + CNT_W'(1);
            end
          end else begin
            run_cnt <= CNT_W'(1);
          end
        end
        ST_LOCKED: begin
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: rtl/video_out_mapper.sv
// Registered output stage: board-dependent lane permutation and sync swap,
// sync polarity, frame-aligned blanking and heartbeat LED.
// Optional colour-bar generator enabled by VIDEO_OUT_MAPPER_TEST_PATTERN_EN.
module video_out_mapper
  import video_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned PIPE_STAGES   = 2,
  parameter int unsigned DETECT_FILTER = 16,
  parameter int unsigned BLINK_PERIOD  = 74_250_000
) (
  input  logic                  clock_video,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_de,
  input  logic                  detect_n,
  input  logic                  map_override_valid,
  input  logic                  map_override,
  input  logic                  hsync_pol,
  input  logic                  vsync_pol,
  input  logic                  out_enable,
`ifdef VIDEO_OUT_MAPPER_TEST_PATTERN_EN
  input  logic                  test_pattern,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic                  out_de,
  output logic                  map_locked,
  output logic                  map_sel,
  output logic                  led
);

  localparam int unsigned BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic                  map_sel_detected;
  map_idx_t              map_active;
  logic [DATA_WIDTH-1:0] src_data;
  logic [MAP1_WIDTH-1:0] map1_low;
  logic [DATA_WIDTH-1:0] stage_data;
  video_ctrl_t           stage_ctrl;
  video_ctrl_t           idle_ctrl;
  logic                  vsync_d;
  logic                  en_req;
  logic                  en_state;
  logic                  en_eff;
  logic                  blank;
  logic                  act_hsync;
  logic                  act_vsync;
  logic [BLINK_W-1:0]    blink_cnt;

  video_out_detect #(
    .DETECT_FILTER(DETECT_FILTER)
  ) u_detect (
    .clock_video     (clock_video),
    .reset_n         (reset_n),
    .detect_n        (detect_n),
    .map_sel_detected(map_sel_detected),
    .map_locked      (map_locked)
  );

  assign map_active = map_idx_t'(map_override_valid ? map_override : map_sel_detected);
  assign map_sel    = map_active;

`ifdef VIDEO_OUT_MAPPER_TEST_PATTERN_EN
  localparam int unsigned PIX_W = BAR_SHIFT + 3;

  logic [PIX_W-1:0]      pix_cnt;
  logic [DATA_WIDTH-1:0] bar_data;

  // Saturating pixel position within the active line; top bits pick the bar
  always_ff @(posedge clock_video) begin
    if (!reset_n || !in_de) begin
      pix_cnt <= '0;
    end else if (pix_cnt != '1) begin
      pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

  always_comb begin
    bar_data       = '0;
    bar_data[23:0] = BAR_RGB[pix_cnt[BAR_SHIFT +: 3]];
  end

  assign src_data = test_pattern ? bar_data : in_data;
`else
  assign src_data = in_data;
`endif

  for (genvar i = 0; i < MAP1_WIDTH; i++) begin : g_map1
    assign map1_low[i] = src_data[MAP1_SRC[i]];
  end

  // Enable follows the registered request only at a vsync rising edge
  always_ff @(posedge clock_video) begin
    if (!reset_n) begin
      vsync_d  <= 1'b1;
      en_req   <= 1'b0;
      en_state <= 1'b0;
    end else begin
      vsync_d  <= in_vsync;
      en_req   <= out_enable;
      en_state <= en_eff;
    end
  end

  assign en_eff    = (in_vsync && !vsync_d) ? en_req : en_state;
  assign blank     = !en_eff || (!map_locked && !map_override_valid);
  assign act_hsync = (map_active == MAP_M5DISPLAY) ? in_vsync : in_hsync;
  assign act_vsync = (map_active == MAP_M5DISPLAY) ? in_hsync : in_vsync;

  always_comb begin
    stage_data = src_data;
    if (map_active == MAP_M5DISPLAY) begin
      stage_data[MAP1_WIDTH-1:0] = map1_low;
    end
    if (blank) begin
      stage_data = '0;
    end
    stage_ctrl.de    = !blank && in_de;
    stage_ctrl.hsync = (!blank && act_hsync) ^ !hsync_pol;
    stage_ctrl.vsync = (!blank && act_vsync) ^ !vsync_pol;
  end

  assign idle_ctrl = '{de: 1'b0, hsync: !hsync_pol, vsync: !vsync_pol};

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    video_ctrl_t           ctrl_q;
    video_ctrl_t           ctrl_d;

    if (s == 0) begin : g_head
      assign data_d = stage_data;
      assign ctrl_d = stage_ctrl;
    end else begin : g_tail
      assign data_d = g_stage[s-1].data_q;
      assign ctrl_d = g_stage[s-1].ctrl_q;
    end

    always_ff @(posedge clock_video) begin
      if (!reset_n) begin
        data_q <= '0;
        ctrl_q <= idle_ctrl;
      end else begin
        data_q <= data_d;
        ctrl_q <= ctrl_d;
      end
    end
  end

  assign out_data  = g_stage[PIPE_STAGES-1].data_q;
  assign out_de    = g_stage[PIPE_STAGES-1].ctrl_q.de;
  assign out_hsync = g_stage[PIPE_STAGES-1].ctrl_q.hsync;
  assign out_vsync = g_stage[PIPE_STAGES-1].ctrl_q.vsync;

  // Heartbeat: toggle led once per BLINK_PERIOD cycles
  always_ff @(posedge clock_video) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      led       <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
      blink_cnt <= '0;
      led       <= ~led;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule
